// File: rtl/mem_access_pkg.sv
//------------------------------------------------------------------------------
// mem_access_pkg
// Shared request codes, controller state encoding and byte-lane helpers for
// the memory access controller.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_access_pkg;

    // Request operation codes
    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // Request size codes
    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_RSVD  = 2'b11;

    // Lane-enable patterns before shifting to the addressed position
    localparam logic [3:0] LANE_BYTE = 4'b0001;
    localparam logic [3:0] LANE_HALF = 4'b0011;
    localparam logic [3:0] LANE_WORD = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WR     = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    // Little-endian byte lanes touched by an access of the given size
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = LANE_BYTE << addr_lo;
            SZ_HALF: mask = LANE_HALF << {addr_lo[1], 1'b0};
            default: mask = LANE_WORD;
        endcase
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/byte_lane_unit.sv
//------------------------------------------------------------------------------
// byte_lane_unit
// Combinational lane logic: extracts and extends load data from a memory word
// and merges right-aligned store data into a memory word.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module byte_lane_unit
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_mask;
    logic [31:0] w_wrep;

    // Select the addressed lane(s) and extend them to a full load result
    always_comb begin
        w_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
        w_half = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
        case (size_i)
            SZ_BYTE: load_o = {{24{signed_i & w_byte[7]}}, w_byte};
            SZ_HALF: load_o = {{16{signed_i & w_half[15]}}, w_half};
            default: load_o = rdata_i;
        endcase
    end

    // Replicate store data across the word, then keep it only in the enabled lanes
    always_comb begin
        w_mask = lane_mask(size_i, addr_lo_i);
        case (size_i)
            SZ_BYTE: w_wrep = {4{wdata_i[7:0]}};
            SZ_HALF: w_wrep = {2{wdata_i[15:0]}};
            default: w_wrep = wdata_i;
        endcase
        for (int k = 0; k < 4; k++) begin
            merge_o[8*k +: 8] = w_mask[k] ? w_wrep[8*k +: 8] : rdata_i[8*k +: 8];
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
//------------------------------------------------------------------------------
// mem_access_ctrl
// Single-request memory-side controller: validates fetch/load/store requests,
// sequences word-wide memory reads/writes (read-modify-write for sub-word
// stores) and captures fetched words into IR and loaded data into MDR.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] instr,
    output logic [31:0] mdr,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_data
);

    localparam logic [31:0] C_MEM_LIMIT = 32'(MEM_BYTES);

    state_e      state_q;
    logic [1:0]  op_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] merge_q;
    logic [31:0] instr_q;
    logic [31:0] mdr_q;

    logic        w_req_err;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    // Classify the incoming request; only meaningful on the accept edge
    always_comb begin
        w_req_err = 1'b0;
        if (req_op == OP_RSVD || req_size == SZ_RSVD)           w_req_err = 1'b1;
        if (req_op == OP_FETCH && req_size != SZ_WORD)          w_req_err = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])                 w_req_err = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)      w_req_err = 1'b1;
        if (req_addr >= C_MEM_LIMIT)                            w_req_err = 1'b1;
    end

    byte_lane_unit u_lanes (
        .rdata_i   (mem_data),
        .addr_lo_i (addr_q[1:0]),
        .size_i    (size_q),
        .signed_i  (signed_q),
        .wdata_i   (wdata_q),
        .load_o    (w_load),
        .merge_o   (w_merge)
    );

    // Request sequencer: latches the request on accept and walks the access states
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_FETCH;
            size_q   <= SZ_WORD;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            merge_q  <= '0;
            instr_q  <= '0;
            mdr_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        err_q    <= w_req_err;
                        if (w_req_err)
                            state_q <= ST_RESP;
                        else if (req_op == OP_STORE)
                            state_q <= (req_size == SZ_WORD) ? ST_WR : ST_RMW_RD;
                        else
                            state_q <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (op_q == OP_FETCH) instr_q <= mem_data;
                    else                  mdr_q   <= w_load;
                    state_q <= ST_RESP;
                end
                ST_WR:     state_q <= ST_RESP;
                ST_RMW_RD: begin
                    merge_q <= w_merge;
                    state_q <= ST_RMW_WR;
                end
                ST_RMW_WR: state_q <= ST_RESP;
                ST_RESP:   state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    // Memory strobes are qualified by reset so an aborted write never reaches memory
    assign req_ready      = (state_q == ST_IDLE);
    assign rsp_valid      = (state_q == ST_RESP);
    assign rsp_err        = (state_q == ST_RESP) & err_q;
    assign mem_read       = ~reset & ((state_q == ST_RD) | (state_q == ST_RMW_RD));
    assign mem_write      = ~reset & ((state_q == ST_WR) | (state_q == ST_RMW_WR));
    assign mem_address    = {addr_q[31:2], 2'b00};
    assign mem_write_data = (state_q == ST_RMW_WR) ? merge_q : wdata_q;
    assign instr          = instr_q;
    assign mdr            = mdr_q;

endmodule

`default_nettype wire
